// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared widths and deframer state encoding
package alu_pkg;

    localparam int ALU_DATA_W  = 32;
    localparam int FRAME_LEN_W = 5;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        RECV,
        DONE
    } dfr_state_t;

endpackage

// File: rtl/alu_deframer_if.sv
// rtl/alu_deframer_if.sv - consumer-side request and replay stream bundle
interface alu_deframer_if;
    import alu_pkg::*;

    logic [FRAME_LEN_W-1:0] req_len;
    logic                   req_val;
    logic                   req_rdy;
    logic [ALU_DATA_W-1:0]  out_data;
    logic                   out_val;
    logic                   out_last;
    logic                   out_rdy;

    modport master (
        output req_len, req_val, out_rdy,
        input  req_rdy, out_data, out_val, out_last
    );

    modport slave (
        input  req_len, req_val, out_rdy,
        output req_rdy, out_data, out_val, out_last
    );

endinterface

// File: rtl/alu_deframer_buf.sv
// rtl/alu_deframer_buf.sv - commit/rollback word buffer with registered head
module alu_deframer_buf
    import alu_pkg::*;
#(
    parameter  int DEPTH = 32,
    localparam int AW    = $clog2(DEPTH),
    localparam int PW    = AW + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [ALU_DATA_W-1:0] wr_data,
    input  logic                  wr_last,
    input  logic                  commit,
    input  logic                  rollback,
    input  logic                  pop,
    output logic [PW-1:0]         free,
    output logic [ALU_DATA_W-1:0] head_data,
    output logic                  head_last,
    output logic                  head_val
);

    logic [ALU_DATA_W:0] mem [DEPTH];
    logic [PW-1:0]       wptr, cptr, rptr;
    logic [PW-1:0]       cptr_nxt, rptr_nxt, cnt;
    logic                full, wr_ok, cmt_empty;

    assign cnt      = wptr - rptr;
    assign free     = PW'(DEPTH) - cnt;
    assign full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign wr_ok    = wr_en && !full && !rollback;
    assign cptr_nxt = commit ? wptr : cptr;
    assign rptr_nxt = rptr + PW'(pop && head_val);
    // Head is refetched every cycle from the post-pop pointer, so a stalled
    // word is simply re-read from a location that cannot yet be overwritten.
    assign cmt_empty = (cptr_nxt == rptr_nxt);

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wptr[AW-1:0]] <= {wr_last, wr_data};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr      <= '0;
            cptr      <= '0;
            rptr      <= '0;
            head_val  <= 1'b0;
            head_data <= '0;
            head_last <= 1'b0;
        end else begin
            if (rollback) begin
                wptr <= cptr;
            end else if (wr_ok) begin
                wptr <= wptr + PW'(1);
            end
            cptr     <= cptr_nxt;
            rptr     <= rptr_nxt;
            head_val <= !cmt_empty;
            if (!cmt_empty) begin
                head_data <= mem[rptr_nxt[AW-1:0]][ALU_DATA_W-1:0];
                head_last <= mem[rptr_nxt[AW-1:0]][ALU_DATA_W];
            end else begin
                head_data <= '0;
                head_last <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_deframer.sv
// rtl/alu_deframer.sv - requests frames from the framer and replays them on a stream
module alu_deframer
    import alu_pkg::*;
#(
    parameter int DEPTH   = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   rst_n,
    alu_deframer_if.slave          cns,
    output logic [FRAME_LEN_W-1:0] frame_len,
    output logic                   frame_len_val,
    input  logic                   frame,
    input  logic [ALU_DATA_W-1:0]  frame_data,
    output logic                   err_len,
    output logic                   err_timeout,
    output logic                   busy
);

    localparam int PW = $clog2(DEPTH) + 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    dfr_state_t             state, state_nxt;
    logic                   frame_r;
    logic [ALU_DATA_W-1:0]  data_r;
    logic [FRAME_LEN_W-1:0] exp_len, rcv, rcv_inc;
    logic [TW-1:0]          tcnt;
    logic                   run, stray_q;
    logic [PW-1:0]          free;
    logic                   req_rdy, accept, tmo_hit, last_hit;
    logic                   wr_en, wr_last, commit, rollback, stray;

    assign rcv_inc  = rcv + FRAME_LEN_W'(1);
    assign last_hit = (rcv_inc == exp_len);
    assign tmo_hit  = (tcnt == TW'(TIMEOUT));
    assign accept   = cns.req_val && req_rdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept && cns.req_len != '0) state_nxt = REQ;
            REQ:  state_nxt = WAIT;
            WAIT: begin
                if (frame_r) begin
                    state_nxt = (exp_len == FRAME_LEN_W'(1)) ? DONE : RECV;
                end else if (tmo_hit) begin
                    state_nxt = IDLE;
                end
            end
            RECV: begin
                if (!frame_r) begin
                    state_nxt = IDLE;
                end else if (last_hit) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_rdy       = 1'b0;
        frame_len     = '0;
        frame_len_val = 1'b0;
        busy          = (state != IDLE);
        wr_en         = 1'b0;
        wr_last       = 1'b0;
        commit        = 1'b0;
        rollback      = 1'b0;
        stray         = 1'b0;
        case (state)
            IDLE: begin
                // run keeps req_rdy low through reset and its release cycle
                req_rdy = run && (free >= PW'(cns.req_len));
                stray   = frame_r;
            end
            REQ: begin
                frame_len_val = 1'b1;
                frame_len     = exp_len;
                stray         = frame_r;
            end
            WAIT: begin
                wr_en   = frame_r;
                wr_last = (exp_len == FRAME_LEN_W'(1));
            end
            RECV: begin
                wr_en    = frame_r;
                wr_last  = last_hit;
                rollback = !frame_r;
            end
            DONE: begin
                commit = 1'b1;
                stray  = frame_r;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run         <= 1'b0;
            frame_r     <= 1'b0;
            data_r      <= '0;
            exp_len     <= '0;
            rcv         <= '0;
            tcnt        <= '0;
            stray_q     <= 1'b0;
            err_len     <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            run     <= 1'b1;
            frame_r <= frame;
            data_r  <= frame_data;
            if (state == IDLE && accept) begin
                exp_len <= cns.req_len;
            end
            if (state == WAIT && frame_r) begin
                rcv <= FRAME_LEN_W'(1);
            end else if (state == RECV && frame_r) begin
                rcv <= rcv_inc;
            end
            if (state == REQ) begin
                tcnt <= '0;
            end else if (state == WAIT) begin
                tcnt <= tcnt + TW'(1);
            end
            // One error per contiguous burst of dropped words
            stray_q     <= stray;
            err_len     <= rollback || (stray && !stray_q);
            err_timeout <= (state == WAIT) && !frame_r && tmo_hit;
        end
    end

    alu_deframer_buf #(.DEPTH(DEPTH)) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_data   (data_r),
        .wr_last   (wr_last),
        .commit    (commit),
        .rollback  (rollback),
        .pop       (cns.out_rdy),
        .free      (free),
        .head_data (cns.out_data),
        .head_last (cns.out_last),
        .head_val  (cns.out_val)
    );

    assign cns.req_rdy = req_rdy;

endmodule

// File: tb/tb_alu_deframer.sv
// tb/tb_alu_deframer.sv - directed self-checking bench for alu_deframer
module tb_alu_deframer;
    import alu_pkg::*;

    localparam int DEPTH   = 32;
    localparam int TIMEOUT = 255;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame = 1'b0;
    logic [31:0] frame_data = '0;
    logic [4:0]  frame_len;
    logic        frame_len_val, err_len, err_timeout, busy;

    alu_deframer_if cns ();

    alu_deframer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cns           (cns),
        .frame_len     (frame_len),
        .frame_len_val (frame_len_val),
        .frame         (frame),
        .frame_data    (frame_data),
        .err_len       (err_len),
        .err_timeout   (err_timeout),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [32:0] outq[$];
    int n_err_len = 0, n_err_tmo = 0, n_flv = 0;
    int flv_len = 0, flv_cyc = 0, tmo_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (cns.out_val && cns.out_rdy) outq.push_back({cns.out_last, cns.out_data});
        if (err_len) n_err_len++;
        if (err_timeout) begin
            n_err_tmo++;
            tmo_cyc = cyc;
        end
        if (frame_len_val) begin
            n_flv++;
            flv_len = int'(frame_len);
            flv_cyc = cyc;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_req(input int len, output int acc, output logic rdy);
        step();
        cns.req_len = 5'(len);
        cns.req_val = 1'b1;
        @(negedge clk);
        rdy = cns.req_rdy;
        acc = cyc;
        step();
        cns.req_val = 1'b0;
    endtask

    task automatic send_words(input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            step();
            frame      = 1'b1;
            frame_data = base + 32'(i);
        end
        step();
        frame = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cns.req_len = '0;
        cns.req_val = 1'b0;
        cns.out_rdy = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (cns.req_rdy !== 1'b0) begin errors++; $display("FAIL reset_req_rdy actual=%0b required=0", cns.req_rdy); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy actual=%0b required=0", busy); end
        checks++; if ({cns.out_val, cns.out_last, cns.out_data} !== 34'h0) begin errors++; $display("FAIL reset_out actual=%0h required=0", {cns.out_val, cns.out_last, cns.out_data}); end
        checks++; if ({frame_len_val, frame_len} !== 6'h0) begin errors++; $display("FAIL reset_frame_len actual=%0h required=0", {frame_len_val, frame_len}); end
        checks++; if ({err_len, err_timeout} !== 2'b00) begin errors++; $display("FAIL reset_err actual=%0b required=00", {err_len, err_timeout}); end
        step();
        rst_n = 1'b1;
        repeat (2) step();
        @(negedge clk);
        checks++; if (cns.req_rdy !== 1'b1) begin errors++; $display("FAIL post_reset_req_rdy actual=%0b required=1", cns.req_rdy); end
    endtask

    task automatic test_single_frame();
        int acc, qs, e0, f0;
        logic rdy;
        logic [32:0] exp_w;
        qs = outq.size(); e0 = n_err_len; f0 = n_flv;
        do_req(4, acc, rdy);
        send_words(4, 32'hA000_0000);
        repeat (10) step();
        checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL single_req_rdy actual=%0b required=1", rdy); end
        checks++; if (n_flv - f0 != 1 || flv_len != 4) begin errors++; $display("FAIL single_flv pulses=%0d len=%0d required 1 pulse len 4", n_flv - f0, flv_len); end
        checks++; if (flv_cyc != acc + 1) begin errors++; $display("FAIL single_flv_latency actual=%0d required=%0d", flv_cyc, acc + 1); end
        checks++; if (outq.size() - qs != 4) begin errors++; $display("FAIL single_count actual=%0d required=4", outq.size() - qs); end
        if (outq.size() - qs >= 4) begin
            for (int i = 0; i < 4; i++) begin
                exp_w = {(i == 3), 32'hA000_0000 + 32'(i)};
                checks++; if (outq[qs + i] !== exp_w) begin errors++; $display("FAIL single_word%0d actual=%0h required=%0h", i, outq[qs + i], exp_w); end
            end
        end
        checks++; if (n_err_len != e0) begin errors++; $display("FAIL single_err_len actual=%0d required=0", n_err_len - e0); end
    endtask

    task automatic test_zero_len();
        int acc, qs, f0;
        logic rdy;
        qs = outq.size(); f0 = n_flv;
        do_req(0, acc, rdy);
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL zero_busy actual=%0b required=0", busy); end
        repeat (4) step();
        checks++; if (rdy !== 1'b1 || n_flv != f0 || outq.size() != qs) begin errors++; $display("FAIL zero_len rdy=%0b flv=%0d out=%0d required 1/0/0", rdy, n_flv - f0, outq.size() - qs); end
    endtask

    task automatic test_short();
        int acc, qs, e0;
        logic rdy;
        logic [32:0] exp_w;
        qs = outq.size(); e0 = n_err_len;
        do_req(5, acc, rdy);
        send_words(3, 32'hB000_0000);
        repeat (6) step();
        checks++; if (n_err_len - e0 != 1) begin errors++; $display("FAIL short_err_len actual=%0d required=1", n_err_len - e0); end
        checks++; if (outq.size() != qs) begin errors++; $display("FAIL short_output actual=%0d required=0", outq.size() - qs); end
        checks++; if (u_dut.u_buf.cnt !== 6'd0) begin errors++; $display("FAIL short_cnt actual=%0d required=0", u_dut.u_buf.cnt); end
        do_req(2, acc, rdy);
        send_words(2, 32'hC000_0000);
        repeat (8) step();
        checks++; if (outq.size() - qs != 2) begin errors++; $display("FAIL short_next_count actual=%0d required=2", outq.size() - qs); end
        if (outq.size() - qs >= 2) begin
            for (int i = 0; i < 2; i++) begin
                exp_w = {(i == 1), 32'hC000_0000 + 32'(i)};
                checks++; if (outq[qs + i] !== exp_w) begin errors++; $display("FAIL short_next_word%0d actual=%0h required=%0h", i, outq[qs + i], exp_w); end
            end
        end
    endtask

    task automatic test_overlong();
        int acc, qs, e0;
        logic rdy;
        logic [32:0] exp_w;
        qs = outq.size(); e0 = n_err_len;
        do_req(2, acc, rdy);
        send_words(4, 32'hD000_0000);
        repeat (8) step();
        checks++; if (n_err_len - e0 != 1) begin errors++; $display("FAIL overlong_err_len actual=%0d required=1", n_err_len - e0); end
        checks++; if (outq.size() - qs != 2) begin errors++; $display("FAIL overlong_count actual=%0d required=2", outq.size() - qs); end
        if (outq.size() - qs >= 2) begin
            for (int i = 0; i < 2; i++) begin
                exp_w = {(i == 1), 32'hD000_0000 + 32'(i)};
                checks++; if (outq[qs + i] !== exp_w) begin errors++; $display("FAIL overlong_word%0d actual=%0h required=%0h", i, outq[qs + i], exp_w); end
            end
        end
    endtask

    task automatic test_back_to_back();
        int acc, qs;
        logic rdy1, rdy2;
        logic [32:0] exp_q[4];
        exp_q[0] = {1'b1, 32'hE000_0000};
        exp_q[1] = {1'b0, 32'hE100_0000};
        exp_q[2] = {1'b0, 32'hE100_0001};
        exp_q[3] = {1'b1, 32'hE100_0002};
        qs = outq.size();
        do_req(1, acc, rdy1);
        send_words(1, 32'hE000_0000);
        repeat (2) step();
        do_req(3, acc, rdy2);
        send_words(3, 32'hE100_0000);
        repeat (8) step();
        checks++; if ({rdy1, rdy2} !== 2'b11) begin errors++; $display("FAIL b2b_req_rdy actual=%0b required=11", {rdy1, rdy2}); end
        checks++; if (outq.size() - qs != 4) begin errors++; $display("FAIL b2b_count actual=%0d required=4", outq.size() - qs); end
        if (outq.size() - qs >= 4) begin
            for (int i = 0; i < 4; i++) begin
                checks++; if (outq[qs + i] !== exp_q[i]) begin errors++; $display("FAIL b2b_word%0d actual=%0h required=%0h", i, outq[qs + i], exp_q[i]); end
            end
        end
    endtask

    task automatic test_timeout();
        int acc, qs, t0, e0;
        logic rdy;
        qs = outq.size(); t0 = n_err_tmo; e0 = n_err_len;
        do_req(3, acc, rdy);
        @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL timeout_busy_rise actual=%0b required=1", busy); end
        repeat (TIMEOUT + 10) step();
        checks++; if (n_err_tmo - t0 != 1) begin errors++; $display("FAIL timeout_pulses actual=%0d required=1", n_err_tmo - t0); end
        checks++; if (tmo_cyc != acc + TIMEOUT + 3) begin errors++; $display("FAIL timeout_cycle actual=%0d required=%0d", tmo_cyc, acc + TIMEOUT + 3); end
        @(negedge clk);
        checks++; if (busy !== 1'b0 || outq.size() != qs || n_err_len != e0) begin errors++; $display("FAIL timeout_after busy=%0b out=%0d err_len=%0d required 0/0/0", busy, outq.size() - qs, n_err_len - e0); end
    endtask

    task automatic test_fill_wrap();
        int acc, qs;
        logic rdy;
        logic [32:0] exp_w;
        qs = outq.size();
        cns.out_rdy = 1'b0;
        do_req(31, acc, rdy);
        send_words(31, 32'hF000_0000);
        repeat (6) step();
        cns.req_len = 5'd31;
        @(negedge clk);
        checks++; if (cns.req_rdy !== 1'b0) begin errors++; $display("FAIL fill_rdy31 actual=%0b required=0", cns.req_rdy); end
        checks++; if (cns.out_val !== 1'b1 || cns.out_data !== 32'hF000_0000) begin errors++; $display("FAIL fill_hold val=%0b data=%0h required 1/f0000000", cns.out_val, cns.out_data); end
        step();
        cns.req_len = 5'd1;
        @(negedge clk);
        checks++; if (cns.req_rdy !== 1'b1) begin errors++; $display("FAIL fill_rdy1 actual=%0b required=1", cns.req_rdy); end
        step();
        cns.out_rdy = 1'b1;
        cns.req_len = 5'd31;
        repeat (40) step();
        @(negedge clk);
        checks++; if (cns.req_rdy !== 1'b1) begin errors++; $display("FAIL drain_rdy31 actual=%0b required=1", cns.req_rdy); end
        checks++; if (outq.size() - qs != 31) begin errors++; $display("FAIL fill_count actual=%0d required=31", outq.size() - qs); end
        if (outq.size() - qs >= 31) begin
            for (int i = 0; i < 31; i++) begin
                exp_w = {(i == 30), 32'hF000_0000 + 32'(i)};
                checks++; if (outq[qs + i] !== exp_w) begin errors++; $display("FAIL fill_word%0d actual=%0h required=%0h", i, outq[qs + i], exp_w); end
            end
        end
    endtask

    task automatic test_reset_mid();
        int acc, qs, e0;
        logic rdy;
        qs = outq.size();
        do_req(8, acc, rdy);
        for (int i = 0; i < 4; i++) begin
            step();
            frame      = 1'b1;
            frame_data = 32'h9000_0000 + 32'(i);
        end
        step();
        rst_n      = 1'b0;
        frame_data = 32'h9000_0004;
        #1;
        checks++; if ({busy, cns.req_rdy, cns.out_val, frame_len_val, err_len, err_timeout} !== 6'b0) begin errors++; $display("FAIL midreset_outputs actual=%0b required=000000", {busy, cns.req_rdy, cns.out_val, frame_len_val, err_len, err_timeout}); end
        e0 = n_err_len;
        step();
        rst_n = 1'b1;
        for (int i = 5; i < 8; i++) begin
            frame_data = 32'h9000_0000 + 32'(i);
            step();
        end
        frame = 1'b0;
        repeat (8) step();
        @(negedge clk);
        checks++; if (n_err_len - e0 != 1) begin errors++; $display("FAIL midreset_err_len actual=%0d required=1", n_err_len - e0); end
        checks++; if (outq.size() != qs) begin errors++; $display("FAIL midreset_output actual=%0d required=0", outq.size() - qs); end
        checks++; if (cns.req_rdy !== 1'b1) begin errors++; $display("FAIL midreset_req_rdy actual=%0b required=1", cns.req_rdy); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_zero_len();
        test_short();
        test_overlong();
        test_back_to_back();
        test_timeout();
        test_fill_wrap();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
